multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle RV32I datapath. It decodes the IR opcode field and sequences each instruction through fetch, decode, execute, memory and writeback. Per state it drives the datapath strobes and the 2-bit `alu_op` code that `alu_control` consumes. Memory accesses use a req/ready handshake, and a retired-instruction counter is kept.

## Interface
Parameters:
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `opcode`  in  7  IR[6:0], valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_read`  out  1  read access.
- `mem_write`  out  1  write access.
- `iord`  out  1  address mux: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load IR.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU zero.
- `pc_source`  out  1  PC mux: 0 = ALU result, 1 = ALUOut.
- `alu_src_a`  out  1  0 = PC, 1 = rs1 register A.
- `alu_src_b`  out  2  00 = B reg, 01 = const 4, 10 = immediate.
- `alu_op`  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- `reg_write`  out  1  register file write.
- `mem_to_reg`  out  1  writeback mux: 0 = ALUOut, 1 = MDR.
- `illegal_instr`  out  1  one-cycle pulse on an unrecognised opcode.
- `instret`  out  INSTRET_W  retired-instruction count.

## Operation
- Supported opcodes: LW 0000011, SW 0100011, R-type 0110011, BEQ 1100011.
- Outputs are Moore-decoded from the state, except where a state's exit depends on `mem_ready`. Any output not listed for a state is 0.
- FETCH: `mem_req`=1, `mem_read`=1, `iord`=0, src_a=PC, src_b=4, `alu_op`=00.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_source`=0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: src_a=PC, src_b=imm, `alu_op`=00 (branch target into ALUOut). Next state:
  - LW or SW → MEM_ADDR.
  - R-type → EXECUTE.
  - BEQ → BRANCH.
  - Any other opcode → FETCH, with `illegal_instr`=1 this cycle and no retire.
- MEM_ADDR: src_a=A, src_b=imm, `alu_op`=00. Next state is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: `mem_req`=1, `mem_read`=1, `iord`=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1. Retire, go to FETCH.
- MEM_WRITE: `mem_req`=1, `mem_write`=1, `iord`=1. Hold until `mem_ready`, then retire and go to FETCH.
- EXECUTE: src_a=A, src_b=B, `alu_op`=10. Go to ALU_WB.
- ALU_WB: `reg_write`=1, `mem_to_reg`=0. Retire, go to FETCH.
- BRANCH: src_a=A, src_b=B, `alu_op`=01, `pc_write_cond`=1, `pc_source`=1. Retire, go to FETCH.
- `instret` increments by 1 on each retire and wraps from all-ones to 0 without flagging.

## Timing
- Reset:
  - While `rst_n`=0, every control output is forced to 0 combinationally, including `mem_req` and `alu_op`=00.
  - At the clock edge the state becomes FETCH and `instret` becomes 0.
  - The first `mem_req` is asserted in the cycle after `rst_n` rises.
- Reset asserted mid-instruction, including during a pending memory access: `mem_req` drops in the same cycle, the instruction is abandoned and not retired, and execution restarts at FETCH.
- Handshake:
  - `mem_req`, `mem_read`/`mem_write` and `iord` stay stable from the first request cycle until the cycle in which `mem_ready`=1.
  - An access completes in exactly that cycle.
  - `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Cycles with zero wait states: LW 5, SW 4, R-type 4, BEQ 3, illegal 2. Each wait cycle adds 1.
- `opcode` is sampled only in DECODE and MEM_ADDR. The IR does not change outside FETCH.

## Structure
- In `definitions_pkg`:
  - `ctrl_state_e` enum: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH.
  - Opcode constants.
  - `alu_op` codes ALUOP_ADD / ALUOP_SUB / ALUOP_FUNCT.
  - src_a and src_b select encodings.
- Single module with a state register, a next-state block, an output decode block and the `instret` counter. No sub-module.

## Test plan
- Reset mid-MEM_READ with `mem_ready`=0: `mem_req`=0 in the same cycle; after release, `mem_req`=1 with `iord`=0, and `instret`=0.
- R-type (0110011) with `mem_ready` tied 1: state sequence FETCH, DECODE, EXECUTE, ALU_WB; `alu_op`=10 in EXECUTE; `reg_write`=1 for one cycle; `instret` 0→1.
- LW with 3 wait cycles in MEM_READ: `mem_req`/`mem_read`/`iord`=1 held for 4 cycles; then MEM_WB with `mem_to_reg`=1; 8 cycles total.
- SW then BEQ: `mem_write`=1 only in MEM_WRITE; BEQ gives `alu_op`=01, `pc_write_cond`=1, `pc_source`=1 for one cycle; `instret`=2.
- Opcode 1111111: `illegal_instr` pulses in DECODE, the next state is FETCH, and `instret` is unchanged.
- INSTRET_W=4: 16 retired R-type instructions → `instret` wraps to 0.

Source files
------------

// File: rtl/definitions_pkg.sv
// -----------------------------------------------------------------------------
// definitions_pkg
// Shared definitions for the multicycle RV32I control path:
//   - ctrl_state_e : main control FSM states
//   - OP_*         : supported major opcodes (IR[6:0])
//   - ALUOP_*      : 2-bit alu_op codes consumed by alu_control
//   - SRCA_* / SRCB_* : ALU operand mux select encodings
//   - is_known_opcode(): true for the opcodes this control path sequences
// -----------------------------------------------------------------------------
package definitions_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEM_ADDR,
      MEM_READ,
      MEM_WB,
      MEM_WRITE,
      EXECUTE,
      ALU_WB,
      BRANCH
   } ctrl_state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic       SRCA_PC   = 1'b0;
   localparam logic       SRCA_REG  = 1'b1;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   function automatic logic is_known_opcode(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE) ||
             (op == OP_RTYPE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle RV32I datapath. Sequences each
// instruction through fetch / decode / execute / memory / writeback and
// drives the datapath strobes for the current state.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   synchronous active-low reset; also forces all control
//                      outputs to 0 combinationally while low
//   opcode        in   IR[6:0], valid from DECODE onward
//   mem_ready     in   memory completes the current access this cycle
//   mem_req/mem_read/mem_write/iord   out  memory access control
//   ir_write, pc_write, pc_write_cond, pc_source   out  IR/PC update control
//   alu_src_a, alu_src_b, alu_op      out  ALU operand and operation select
//   reg_write, mem_to_reg             out  register file writeback control
//   illegal_instr out  one-cycle pulse in DECODE for an unrecognised opcode
//   instret       out  retired-instruction count (wraps silently)
// -----------------------------------------------------------------------------
module multicycle_control
   import definitions_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 iord,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic                 pc_source,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic                 reg_write,
   output logic                 mem_to_reg,
   output logic                 illegal_instr,
   output logic [INSTRET_W-1:0] instret
);

   localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

   ctrl_state_e           state_reg;
   ctrl_state_e           state_next;
   logic [INSTRET_W-1:0]  instret_reg;
   logic                  retire;

   // State register and retired-instruction counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= FETCH;
         instret_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (retire) begin
            instret_reg <= instret_reg + INSTRET_ONE;
         end
      end
   end

   // Next state and retire strobe
   always_comb begin
      state_next = state_reg;
      retire     = 1'b0;
      case (state_reg)
         FETCH: begin
            if (mem_ready) state_next = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_next = MEM_ADDR;
               OP_RTYPE:          state_next = EXECUTE;
               OP_BRANCH:         state_next = BRANCH;
               default:           state_next = FETCH;   // illegal: abandon, no retire
            endcase
         end
         MEM_ADDR: begin
            state_next = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            if (mem_ready) state_next = MEM_WB;
         end
         MEM_WB: begin
            retire     = 1'b1;
            state_next = FETCH;
         end
         MEM_WRITE: begin
            // A store retires in the cycle its write access completes
            if (mem_ready) begin
               retire     = 1'b1;
               state_next = FETCH;
            end
         end
         EXECUTE: begin
            state_next = ALU_WB;
         end
         ALU_WB: begin
            retire     = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            retire     = 1'b1;
            state_next = FETCH;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   // Output decode. Moore from the state, except the FETCH IR/PC load which
   // fires on the completing memory cycle. Everything is held at 0 while
   // rst_n is low so a pending access is dropped in the reset cycle itself.
   always_comb begin
      mem_req       = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_REG;
      alu_op        = ALUOP_ADD;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      illegal_instr = 1'b0;
      if (rst_n) begin
         case (state_reg)
            FETCH: begin
               mem_req   = 1'b1;
               mem_read  = 1'b1;
               alu_src_a = SRCA_PC;
               alu_src_b = SRCB_FOUR;
               alu_op    = ALUOP_ADD;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
               end
            end
            DECODE: begin
               // PC + imm precomputes the branch target into ALUOut
               alu_src_a     = SRCA_PC;
               alu_src_b     = SRCB_IMM;
               alu_op        = ALUOP_ADD;
               illegal_instr = !is_known_opcode(opcode);
            end
            MEM_ADDR: begin
               alu_src_a = SRCA_REG;
               alu_src_b = SRCB_IMM;
               alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
               mem_req  = 1'b1;
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
               mem_req   = 1'b1;
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            EXECUTE: begin
               alu_src_a = SRCA_REG;
               alu_src_b = SRCB_REG;
               alu_op    = ALUOP_FUNCT;
            end
            ALU_WB: begin
               reg_write = 1'b1;
            end
            BRANCH: begin
               alu_src_a     = SRCA_REG;
               alu_src_b     = SRCB_REG;
               alu_op        = ALUOP_SUB;
               pc_write_cond = 1'b1;
               pc_source     = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench: each instruction is expanded into the list of cycles
// it must take (with chosen wait states), every cycle's control bundle is
// compared against values taken from the per-state table, and instret is
// tracked as a plain count. A second instance with INSTRET_W=4 shares the
// stimulus to cover counter wrap.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] BEQ = 7'b1100011;

   typedef enum {
      PH_FETCH, PH_DECODE, PH_ADDR, PH_READ, PH_MWB,
      PH_WRITE, PH_EXEC, PH_AWB, PH_BRANCH
   } phase_t;

   typedef struct {
      phase_t ph;
      logic   rdy;
   } step_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        mem_ready;

   logic        mem_req, mem_read, mem_write, iord, ir_write, pc_write;
   logic        pc_write_cond, pc_source, alu_src_a, reg_write, mem_to_reg;
   logic        illegal_instr;
   logic [1:0]  alu_src_b, alu_op;
   logic [31:0] instret;

   logic        u_mem_req, u_mem_read, u_mem_write, u_iord, u_ir_write, u_pc_write;
   logic        u_pc_write_cond, u_pc_source, u_alu_src_a, u_reg_write, u_mem_to_reg;
   logic        u_illegal_instr;
   logic [1:0]  u_alu_src_b, u_alu_op;
   logic [3:0]  instret4;

   int          n_compared   = 0;
   int          n_mismatched = 0;
   longint      model_count  = 0;   // retired instructions since last reset

   logic [15:0] ctrl_vec;
   assign ctrl_vec = {mem_req, mem_read, mem_write, iord, ir_write, pc_write,
                      pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
                      reg_write, mem_to_reg, illegal_instr};

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .illegal_instr(illegal_instr), .instret(instret)
   );

   multicycle_control #(.INSTRET_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(u_mem_req), .mem_read(u_mem_read), .mem_write(u_mem_write), .iord(u_iord),
      .ir_write(u_ir_write), .pc_write(u_pc_write), .pc_write_cond(u_pc_write_cond),
      .pc_source(u_pc_source), .alu_src_a(u_alu_src_a), .alu_src_b(u_alu_src_b),
      .alu_op(u_alu_op), .reg_write(u_reg_write), .mem_to_reg(u_mem_to_reg),
      .illegal_instr(u_illegal_instr), .instret(instret4)
   );

   task automatic check_value(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Expected control bundle for one cycle, straight from the per-state table
   function automatic logic [15:0] expect_ctrl(input phase_t ph, input logic rdy,
                                               input logic [6:0] op);
      logic req = 0, rd = 0, wr = 0, io = 0, irw = 0, pcw = 0, pcc = 0, pcs = 0;
      logic sa = 0, regw = 0, m2r = 0, ill = 0;
      logic [1:0] sb = 2'b00, aop = 2'b00;
      case (ph)
         PH_FETCH:  begin req = 1; rd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
         PH_DECODE: begin sb = 2'b10; ill = !(op == LW || op == SW || op == RT || op == BEQ); end
         PH_ADDR:   begin sa = 1; sb = 2'b10; end
         PH_READ:   begin req = 1; rd = 1; io = 1; end
         PH_MWB:    begin regw = 1; m2r = 1; end
         PH_WRITE:  begin req = 1; wr = 1; io = 1; end
         PH_EXEC:   begin sa = 1; aop = 2'b10; end
         PH_AWB:    begin regw = 1; end
         PH_BRANCH: begin sa = 1; aop = 2'b01; pcc = 1; pcs = 1; end
         default:   begin end
      endcase
      return {req, rd, wr, io, irw, pcw, pcc, pcs, sa, sb, aop, regw, m2r, ill};
   endfunction

   // Cycle list of one instruction: fetch waits, memory waits
   function automatic void build_steps(input logic [6:0] op, input int wf, input int wm,
                                       ref step_t q[$]);
      q.delete();
      for (int i = 0; i < wf; i++) q.push_back('{PH_FETCH, 1'b0});
      q.push_back('{PH_FETCH, 1'b1});
      q.push_back('{PH_DECODE, 1'($urandom_range(1, 0))});
      case (op)
         LW: begin
            q.push_back('{PH_ADDR, 1'($urandom_range(1, 0))});
            for (int i = 0; i < wm; i++) q.push_back('{PH_READ, 1'b0});
            q.push_back('{PH_READ, 1'b1});
            q.push_back('{PH_MWB, 1'($urandom_range(1, 0))});
         end
         SW: begin
            q.push_back('{PH_ADDR, 1'($urandom_range(1, 0))});
            for (int i = 0; i < wm; i++) q.push_back('{PH_WRITE, 1'b0});
            q.push_back('{PH_WRITE, 1'b1});
         end
         RT: begin
            q.push_back('{PH_EXEC, 1'($urandom_range(1, 0))});
            q.push_back('{PH_AWB, 1'($urandom_range(1, 0))});
         end
         BEQ: q.push_back('{PH_BRANCH, 1'($urandom_range(1, 0))});
         default: begin end
      endcase
   endfunction

   // Called at posedge+1. Runs `cut` cycles of the instruction (all when cut<0).
   // Returns the number of cycles actually executed.
   task automatic run_instr(input logic [6:0] op, input int wf, input int wm,
                            input int cut, output int ncyc);
      step_t q[$];
      build_steps(op, wf, wm, q);
      ncyc = 0;
      foreach (q[i]) begin
         if (cut >= 0 && i >= cut) break;
         opcode    = op;
         mem_ready = q[i].rdy;
         @(negedge clk);
         check_value("ctrl", 32'(ctrl_vec), 32'(expect_ctrl(q[i].ph, q[i].rdy, op)));
         check_value("instret", instret, 32'(model_count));
         check_value("instret4", 32'(instret4), 32'(model_count % 16));
         @(posedge clk);
         #1;
         ncyc++;
         if (q[i].ph inside {PH_MWB, PH_AWB, PH_BRANCH} ||
             (q[i].ph == PH_WRITE && q[i].rdy)) begin
            model_count++;
         end
      end
      $display("instr op=%b wf=%0d wm=%0d cut=%0d cycles=%0d instret=%0d",
               op, wf, wm, cut, ncyc, instret);
   endtask

   // Called at posedge+1. Holds reset for n cycles.
   task automatic apply_reset(input int n);
      rst_n     = 1'b0;
      mem_ready = 1'($urandom_range(1, 0));
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         check_value("rst_ctrl", 32'(ctrl_vec), 32'h0);
         if (c > 0) check_value("rst_instret", instret, 32'h0);
         @(posedge clk);
         #1;
      end
      model_count = 0;
      rst_n = 1'b1;
      $display("reset cycles=%0d", n);
   endtask

   function automatic logic [6:0] rand_opcode();
      logic [6:0] op;
      int sel = $urandom_range(9, 0);
      case (sel)
         0, 1:    op = LW;
         2, 3:    op = SW;
         4, 5, 6: op = RT;
         7, 8:    op = BEQ;
         default: begin
            op = 7'($urandom);
            if (op == LW || op == SW || op == RT || op == BEQ) op = 7'b1111111;
         end
      endcase
      return op;
   endfunction

   initial begin
      int nc;
      rst_n     = 1'b0;
      opcode    = 7'd0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      apply_reset(2);

      // R-type, zero waits: 4 cycles, 0 -> 1
      run_instr(RT, 0, 0, -1, nc);
      check_value("rtype_cycles", 32'(nc), 32'd4);
      check_value("rtype_instret", instret, 32'd1);

      // LW with 3 wait cycles in MEM_READ: 8 cycles
      run_instr(LW, 0, 3, -1, nc);
      check_value("lw_cycles", 32'(nc), 32'd8);

      // SW then BEQ
      run_instr(SW, 1, 2, -1, nc);
      run_instr(BEQ, 0, 0, -1, nc);
      check_value("beq_cycles", 32'(nc), 32'd3);
      check_value("sw_beq_instret", instret, 32'd4);

      // Illegal opcode: 2 cycles, no retire
      run_instr(7'b1111111, 0, 0, -1, nc);
      check_value("illegal_cycles", 32'(nc), 32'd2);
      check_value("illegal_instret", instret, 32'd4);

      // Reset mid-MEM_READ with mem_ready low (fetch, decode, addr, 2 read waits)
      run_instr(LW, 0, 5, 5, nc);
      apply_reset(1);
      run_instr(RT, 0, 0, -1, nc);
      check_value("post_rst_instret", instret, 32'd1);

      // 16 retired R-types on top: the 4-bit counter must wrap back to 1
      for (int i = 0; i < 16; i++) run_instr(RT, 0, 0, -1, nc);
      check_value("wrap_instret4", 32'(instret4), 32'd1);
      check_value("wrap_instret", instret, 32'd17);

      // Randomized mix with occasional mid-instruction resets
      for (int i = 0; i < 250; i++) begin
         logic [6:0] op = rand_opcode();
         int wf = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0;
         int wm = $urandom_range(3, 0);
         if ($urandom_range(24, 0) == 0) begin
            run_instr(op, wf, wm, $urandom_range(3, 0), nc);
            apply_reset($urandom_range(3, 1));
         end else begin
            run_instr(op, wf, wm, -1, nc);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
